// File: rtl/irq_dispatch_if.sv
// Purpose : CPU <-> interrupt dispatcher signal bundle.
// master  : CPU side (IRQ lines, instruction/decoder strobes, push/vector acks).
// slave   : dispatcher side (push request, IF clear, vector, IME, status).
interface irq_dispatch_if;
   logic [4:0] IRQ_REQ;
   logic       INSTR_END;
   logic       EI;
   logic       DI;
   logic       RETI;
   logic       PUSH_REQ;
   logic       PUSH_DONE;
   logic [4:0] IRQ_CLR;
   logic [7:0] VEC;
   logic       VEC_VALID;
   logic       VEC_ACK;
   logic       IME;
   logic       DISPATCH;
   logic       WAKE;

   modport master (
      output IRQ_REQ, INSTR_END, EI, DI, RETI, PUSH_DONE, VEC_ACK,
      input  PUSH_REQ, IRQ_CLR, VEC, VEC_VALID, IME, DISPATCH, WAKE
   );

   modport slave (
      input  IRQ_REQ, INSTR_END, EI, DI, RETI, PUSH_DONE, VEC_ACK,
      output PUSH_REQ, IRQ_CLR, VEC, VEC_VALID, IME, DISPATCH, WAKE
   );
endinterface

// File: rtl/irq_dispatch.sv
// Purpose : Interrupt dispatcher. Arbitrates five prioritised IRQ lines at
//           instruction boundaries, sequences PC push / IF clear / vector load,
//           and owns the interrupt master enable (EI delay, DI, RETI).
// Ports   : CLK  - system clock (rising edge)
//           nRES - asynchronous active-low reset
//           bus  - irq_dispatch_if.slave (IRQ_REQ, INSTR_END, EI, DI, RETI,
//                  PUSH_REQ/PUSH_DONE, IRQ_CLR, VEC/VEC_VALID/VEC_ACK, IME,
//                  DISPATCH, WAKE)
// Config  : `define IRQ_DISPATCH_CANCEL_EN -> priority taken from live IRQ_REQ
//           when leaving PUSH; an empty request cancels (VEC=0, no IRQ_CLR).
//           Default -> priority snapshotted when dispatch starts.
module irq_dispatch (
   input logic         CLK,
   input logic         nRES,
   irq_dispatch_if.slave bus
);
   localparam int unsigned NUM_IRQ = 5;
   localparam int unsigned VEC_W   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PUSH   = 2'd1,
      SELECT = 2'd2,
      VECTOR = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 ime_q, ime_d;
   logic                 ei_q, ei_d;
   logic                 wake_q;
   logic                 push_req_q, push_req_d;
   logic [NUM_IRQ-1:0]   irq_clr_q, irq_clr_d;
   logic [VEC_W-1:0]     vec_q, vec_d;
   logic                 vec_valid_q, vec_valid_d;
   logic                 dispatch_q, dispatch_d;
   logic [NUM_IRQ-1:0]   src;
   logic [NUM_IRQ-1:0]   sel_onehot;
   logic [VEC_W-1:0]     sel_vec;
   logic                 take_irq;

   // Vector table: 0x40 + 8*n for the one-hot selected source n.
   function automatic logic [VEC_W-1:0] vec_of(input logic [NUM_IRQ-1:0] oh);
      logic [VEC_W-1:0] v;
      v = '0;
      case (oh)
         5'b00001: v = 8'h40;
         5'b00010: v = 8'h48;
         5'b00100: v = 8'h50;
         5'b01000: v = 8'h58;
         5'b10000: v = 8'h60;
         default:  v = 8'h00;
      endcase
      return v;
   endfunction

`ifdef IRQ_DISPATCH_CANCEL_EN
   // Live request at the PUSH->SELECT edge; a dropped request cancels.
   assign src = bus.IRQ_REQ;
`else
   logic [NUM_IRQ-1:0] snap_q;

   // Priority snapshot captured when the dispatch is committed.
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES)                                  snap_q <= '0;
      else if (state_q == IDLE && state_d == PUSH) snap_q <= bus.IRQ_REQ;
   end

   assign src = snap_q;
`endif

   // Isolate the lowest set bit (bit 0 = highest priority).
   assign sel_onehot = NUM_IRQ'(src & (~src + NUM_IRQ'(1)));
   assign sel_vec    = vec_of(sel_onehot);

   assign take_irq = (state_q == IDLE) && bus.INSTR_END && ime_q &&
                     (|bus.IRQ_REQ) && !bus.DI;

   // State register and registered outputs.
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         state_q     <= IDLE;
         ime_q       <= 1'b0;
         ei_q        <= 1'b0;
         wake_q      <= 1'b0;
         push_req_q  <= 1'b0;
         irq_clr_q   <= '0;
         vec_q       <= '0;
         vec_valid_q <= 1'b0;
         dispatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ime_q       <= ime_d;
         ei_q        <= ei_d;
         wake_q      <= |bus.IRQ_REQ;
         push_req_q  <= push_req_d;
         irq_clr_q   <= irq_clr_d;
         vec_q       <= vec_d;
         vec_valid_q <= vec_valid_d;
         dispatch_q  <= dispatch_d;
      end
   end

   // Next-state, IME control and next-output decode.
   always_comb begin
      state_d   = state_q;
      ime_d     = ime_q;
      ei_d      = ei_q;
      irq_clr_d = '0;
      vec_d     = vec_q;

      case (state_q)
         IDLE:   if (take_irq) state_d = PUSH;
         PUSH: begin
            if (bus.PUSH_DONE) begin
               state_d   = SELECT;
               irq_clr_d = sel_onehot;
               vec_d     = sel_vec;
            end
         end
         SELECT: state_d = VECTOR;
         VECTOR: if (bus.VEC_ACK) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // EI takes effect at the first boundary strictly after the EI cycle.
      if (ei_q && bus.INSTR_END) begin
         ime_d = 1'b1;
         ei_d  = 1'b0;
      end
      if (bus.EI) ei_d = 1'b1;
      if (bus.RETI && state_q == IDLE) ime_d = 1'b1;
      if (take_irq) ime_d = 1'b0;
      // DI has the final word over every other IME source.
      if (bus.DI) begin
         ime_d = 1'b0;
         ei_d  = 1'b0;
      end

      push_req_d  = (state_d == PUSH);
      vec_valid_d = (state_d == VECTOR);
      dispatch_d  = (state_d != IDLE);
   end

   assign bus.PUSH_REQ  = push_req_q;
   assign bus.IRQ_CLR   = irq_clr_q;
   assign bus.VEC       = vec_q;
   assign bus.VEC_VALID = vec_valid_q;
   assign bus.IME       = ime_q;
   assign bus.DISPATCH  = dispatch_q;
   assign bus.WAKE      = wake_q;
endmodule
